// File: rtl/kalman_pkg.sv
// Shared types and defaults for the Kalman noise-matrix datapath.
// Consumers import this package for the fp64 type, the matrix select tag and the reader states.
package kalman_pkg;

  localparam int unsigned DEFAULT_STATE_DIM   = 12;
  localparam int unsigned DEFAULT_MEASURE_DIM = 6;
  localparam int unsigned DEFAULT_IDX_W       = 4;

  typedef logic [63:0] fp64_t;

  typedef enum logic {
    SEL_Q = 1'b0,
    SEL_R = 1'b1
  } noise_sel_e;

  typedef enum logic [1:0] {
    StIdle,
    StWaitRdy,
    StStream,
    StDone
  } reader_state_e;

endpackage

// File: rtl/tri_index_counter.sv
// Row-major (row, col) walker over an N x N matrix, optionally restricted to the upper triangle.
// row/col always name the element that will be fetched next; wrap flags the final element.
module tri_index_counter #(
  parameter int unsigned N     = 12,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             sym,
  input  logic             clear,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             wrap
);

  localparam logic [IDX_W-1:0] Last = IDX_W'(N - 1);

  assign wrap = (row == Last) && (col == Last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (wrap) begin
        row <= '0;
        col <= '0;
      end else if (col == Last) begin
        row <= row + 1'b1;
        // Upper-triangle rows start on the diagonal.
        col <= sym ? row + 1'b1 : '0;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/noise_matrix_reader.sv
// Serializes Q_k then R_k into a tagged 64-bit valid/ready element stream, one beat per cycle.
// The element mux is driven by the next-index counters and captured in a registered output stage.
module noise_matrix_reader
  import kalman_pkg::*;
#(
  parameter int unsigned STATE_DIM   = DEFAULT_STATE_DIM,
  parameter int unsigned MEASURE_DIM = DEFAULT_MEASURE_DIM,
  parameter int unsigned IDX_W       = DEFAULT_IDX_W
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [STATE_DIM-1:0][STATE_DIM-1:0][63:0]     Q_k,
  input  logic [MEASURE_DIM-1:0][MEASURE_DIM-1:0][63:0] R_k,
  input  logic                                         matrices_ready,
  input  logic                                         start,
  input  logic                                         sym_mode,
  input  logic                                         abort,
  output logic                                         elem_valid,
  input  logic                                         elem_ready,
  output logic [63:0]                                  elem_data,
  output logic                                         elem_sel,
  output logic [IDX_W-1:0]                             elem_row,
  output logic [IDX_W-1:0]                             elem_col,
  output logic                                         elem_last,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         stale
);

  localparam int unsigned QW = (STATE_DIM > 1) ? $clog2(STATE_DIM) : 1;
  localparam int unsigned RW = (MEASURE_DIM > 1) ? $clog2(MEASURE_DIM) : 1;

  reader_state_e state_q, state_d;
  noise_sel_e    src_q, src_d;
  logic          sym_q;

  logic             load, accept, clear, hs, sym_eff;
  logic             q_step, r_step, q_wrap, r_wrap;
  logic [IDX_W-1:0] q_row, q_col, r_row, r_col;

  fp64_t            nxt_data;
  noise_sel_e       nxt_sel;
  logic [IDX_W-1:0] nxt_row, nxt_col;
  logic             nxt_last;

  assign hs = elem_valid & elem_ready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept = 1'b1;
          if (matrices_ready) begin
            load    = 1'b1;
            state_d = StStream;
          end else begin
            state_d = StWaitRdy;
          end
        end
      end
      StWaitRdy: begin
        if (abort) begin
          state_d = StIdle;
        end else if (matrices_ready) begin
          load    = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        // abort wins over a same-cycle handshake; that beat is treated as not consumed.
        if (abort) begin
          state_d = StIdle;
        end else if (hs) begin
          if (elem_last) state_d = StDone;
          else           load    = 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign clear   = (state_q == StDone) ||
                   (abort && ((state_q == StWaitRdy) || (state_q == StStream)));
  // The first load happens in the same edge that latches sym_mode.
  assign sym_eff = (state_q == StIdle) ? sym_mode : sym_q;
  assign q_step  = load && (src_q == SEL_Q);
  assign r_step  = load && (src_q == SEL_R);

  always_comb begin
    src_d = src_q;
    if (clear)               src_d = SEL_Q;
    else if (q_step && q_wrap) src_d = SEL_R;
  end

  tri_index_counter #(
    .N     (STATE_DIM),
    .IDX_W (IDX_W)
  ) u_q_cnt (
    .clk   (clk),
    .rst   (rst),
    .step  (q_step),
    .sym   (sym_eff),
    .clear (clear),
    .row   (q_row),
    .col   (q_col),
    .wrap  (q_wrap)
  );

  tri_index_counter #(
    .N     (MEASURE_DIM),
    .IDX_W (IDX_W)
  ) u_r_cnt (
    .clk   (clk),
    .rst   (rst),
    .step  (r_step),
    .sym   (sym_eff),
    .clear (clear),
    .row   (r_row),
    .col   (r_col),
    .wrap  (r_wrap)
  );

  always_comb begin
    nxt_data = '0;
    nxt_sel  = src_q;
    nxt_row  = '0;
    nxt_col  = '0;
    nxt_last = 1'b0;
    if (src_q == SEL_Q) begin
      nxt_data = Q_k[q_row[QW-1:0]][q_col[QW-1:0]];
      nxt_row  = q_row;
      nxt_col  = q_col;
    end else begin
      nxt_data = R_k[r_row[RW-1:0]][r_col[RW-1:0]];
      nxt_row  = r_row;
      nxt_col  = r_col;
      nxt_last = r_wrap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      src_q   <= SEL_Q;
      sym_q   <= 1'b0;
      stale   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      if (accept) begin
        sym_q <= sym_mode;
        stale <= 1'b0;
      end else if ((state_q == StStream) && !matrices_ready) begin
        stale <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_valid <= 1'b0;
      elem_data  <= '0;
      elem_sel   <= 1'b0;
      elem_row   <= '0;
      elem_col   <= '0;
      elem_last  <= 1'b0;
    end else if (load) begin
      elem_valid <= 1'b1;
      elem_data  <= nxt_data;
      elem_sel   <= nxt_sel;
      elem_row   <= nxt_row;
      elem_col   <= nxt_col;
      elem_last  <= nxt_last;
    end else if ((state_q == StStream) && (abort || hs)) begin
      elem_valid <= 1'b0;
      elem_last  <= 1'b0;
    end
  end

  assign busy = (state_q == StWaitRdy) || (state_q == StStream);
  assign done = (state_q == StDone);

endmodule
